ins_mem_loader: RTL and testbench

INS_MEM_LOADER -- requirements
Module: ins_mem_loader

---
 rtl/ins_mem_loader.sv | 159 +++++++++++++++
 tb/tb_ins_mem_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: receives an instruction image over a valid/ready word stream
// (length header, payload, optional checksum), writes it into instruction memory
// and releases the fetch PC once the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds the trailing XOR checksum word.
// DEPTH is expected to be at least 2 so the address port is at least 1 bit wide.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for load_start after reset
// LEN   | waiting for the length header word
// DATA  | accepting payload words, one memory write per word
// CSUM  | waiting for the checksum word (LOADER_CHECKSUM_EN builds only)
// DONE  | image loaded, PC released one cycle after entry
// ERROR | load aborted, memory left as partially written, PC held
module ins_mem_loader #(
   parameter int DEPTH = 64
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       load_start,
   input  logic [31:0]                data_in,
   input  logic                       data_valid,
   output logic                       data_ready,
   output logic                       mem_write_en,
   output logic [$clog2(DEPTH)-1:0]   mem_write_addr,
   output logic [31:0]                mem_write_data,
   output logic                       PC_write,
   output logic                       load_done,
   output logic                       load_error
);

   localparam int AW = $clog2(DEPTH);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;
`else
   typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;
`endif

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   addr_cnt;
   logic [AW-1:0]   rem_cnt;
   logic            accept_start;
   logic            len_ok;
   logic            data_xfer;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]     csum_acc;
`endif

   assign len_ok    = (data_in != 32'd0) && (data_in <= 32'(DEPTH));
   assign data_xfer = (state == DATA) && data_valid;

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode and stream handshake
   always_comb begin
      state_nxt    = state;
      data_ready   = 1'b0;
      accept_start = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (load_start) begin
               accept_start = 1'b1;
               state_nxt    = LEN;
            end
         end
         LEN: begin
            data_ready = 1'b1;
            if (data_valid) begin
               state_nxt = len_ok ? DATA : ERROR;
            end
         end
         DATA: begin
            data_ready = 1'b1;
            // rem_cnt reaching zero marks the N-th payload word
            if (data_valid && (rem_cnt == '0)) begin
`ifdef LOADER_CHECKSUM_EN
               state_nxt = CSUM;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            data_ready = 1'b1;
            if (data_valid) begin
               state_nxt = (data_in == csum_acc) ? DONE : ERROR;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // address counter, remaining-word down-counter and registered write port
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_cnt       <= '0;
         rem_cnt        <= '0;
         mem_write_en   <= 1'b0;
         mem_write_addr <= '0;
         mem_write_data <= 32'd0;
      end else begin
         mem_write_en <= 1'b0;
         if (accept_start) begin
            addr_cnt <= '0;
            rem_cnt  <= '0;
         end
         if ((state == LEN) && data_valid) begin
            rem_cnt <= AW'(data_in - 32'd1);
         end
         if (data_xfer) begin
            mem_write_en   <= 1'b1;
            mem_write_addr <= addr_cnt;
            mem_write_data <= data_in;
            addr_cnt       <= addr_cnt + 1'b1;
            rem_cnt        <= rem_cnt - 1'b1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // running XOR of accepted payload words
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         csum_acc <= 32'd0;
      end else if (accept_start) begin
         csum_acc <= 32'd0;
      end else if (data_xfer) begin
         csum_acc <= csum_acc ^ data_in;
      end
   end
`endif

   // PC release is registered so it trails DONE entry by one cycle and drops
   // together with the restart that leaves DONE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         PC_write <= 1'b0;
      end else begin
         PC_write <= (state == DONE) && !load_start;
      end
   end

   assign load_done  = (state == DONE);
   assign load_error = (state == ERROR);

endmodule

// File: tb/tb_ins_mem_loader.sv
// Bench for ins_mem_loader: table of load scenarios plus randomized loads,
// scored against the image the bench itself streams in.
module tb_ins_mem_loader;

   localparam int DEPTH = 64;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset_n;
   logic          load_start;
   logic [31:0]   data_in;
   logic          data_valid;
   logic          data_ready;
   logic          mem_write_en;
   logic [5:0]    mem_write_addr;
   logic [31:0]   mem_write_data;
   logic          pc_write;
   logic          load_done;
   logic          load_error;

   ins_mem_loader #(.DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .load_start     (load_start),
      .data_in        (data_in),
      .data_valid     (data_valid),
      .data_ready     (data_ready),
      .mem_write_en   (mem_write_en),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .PC_write       (pc_write),
      .load_done      (load_done),
      .load_error     (load_error)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   int n_writes = 0;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      string       tag;
      logic [31:0] len;
      bit          fixed;
      bit          bad_csum;
      int          gap;
      bit          ok_cs;
      bit          ok_nocs;
      int          writes;
   } vec_t;
   vec_t vecs[8];

   logic [31:0] fixed_img[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // a transfer happened at this edge (pre-edge handshake values)
   logic xfer_q;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) xfer_q <= 1'b0;
      else          xfer_q <= data_valid && data_ready;
   end

   // every write must follow a transfer and match the next expected image word
   always @(negedge clock) begin : wr_mon
      wr_t e;
      if (reset_n && mem_write_en) begin
         n_writes++;
         check("write_follows_xfer", 32'(xfer_q), 32'd1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d data 0x%08h want no write", mem_write_addr, mem_write_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_write_addr), 32'(e.addr));
            check("wr_data", mem_write_data, e.data);
         end
      end
   end

   task automatic send(input logic [31:0] w, input int max_gap);
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
         data_valid = 1'b0;
         data_in    = $urandom;
         @(negedge clock);
      end
      data_valid = 1'b1;
      data_in    = w;
      @(negedge clock);
      data_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
   endtask

   // one complete load; expected outcome and write count supplied by caller
   task automatic run_load(input string tag, input logic [31:0] len, input bit fixed,
                           input bit bad_csum, input int max_gap, input bit do_start,
                           input bit exp_ok, input int exp_writes);
      logic [31:0] acc;
      logic [31:0] w;
      int          w0;
      bit          len_ok;
      acc    = 32'd0;
      w0     = n_writes;
      len_ok = (len >= 1) && (len <= DEPTH);
      if (do_start) pulse_start();
      check({tag, "_ready_len"}, 32'(data_ready), 32'd1);
      send(len, max_gap);
      if (len_ok) begin
         for (int i = 0; i < int'(len); i++) begin
            w = fixed ? fixed_img[i] : $urandom;
            exp_q.push_back('{addr: 6'(i), data: w});
            acc ^= w;
            send(w, max_gap);
         end
`ifdef LOADER_CHECKSUM_EN
         check({tag, "_csum_wait"}, 32'(data_ready), 32'd1);
         check({tag, "_csum_notdone"}, 32'(load_done), 32'd0);
         send(bad_csum ? (fixed ? 32'h0030A192 : ~acc) : acc, max_gap);
`endif
      end else begin
         repeat (3) begin
            data_valid = 1'b1;
            data_in    = $urandom;
            @(negedge clock);
            check({tag, "_no_consume"}, 32'(data_ready), 32'd0);
         end
         data_valid = 1'b0;
      end
      check({tag, "_done"}, 32'(load_done), 32'(exp_ok));
      check({tag, "_error"}, 32'(load_error), 32'(!exp_ok));
      check({tag, "_ready_end"}, 32'(data_ready), 32'd0);
      check({tag, "_pc_entry"}, 32'(pc_write), 32'd0);
      @(negedge clock);
      check({tag, "_pc_after"}, 32'(pc_write), 32'(exp_ok));
      check({tag, "_writes"}, 32'(n_writes - w0), 32'(exp_writes));
      check({tag, "_wr_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] len;
      logic [31:0] w;
      bit          bad;
      bit          ok;
      int          w0;

      // checksum is the XOR of the payload words
      fixed_img[0] = 32'h00000013;
      fixed_img[1] = 32'h00100093;
      fixed_img[2] = 32'h00208113;

      vecs[0] = '{"img_good",  32'd3,          1'b1, 1'b0, 0, 1'b1, 1'b1, 3};
      vecs[1] = '{"img_badcs", 32'd3,          1'b1, 1'b1, 0, 1'b0, 1'b1, 3};
      vecs[2] = '{"len0",      32'd0,          1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[3] = '{"len65",     32'd65,         1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[4] = '{"len64_gap", 32'd64,         1'b0, 1'b0, 2, 1'b1, 1'b1, 64};
      vecs[5] = '{"len1",      32'd1,          1'b0, 1'b0, 1, 1'b1, 1'b1, 1};
      vecs[6] = '{"len_huge",  32'hFFFFFFFF,   1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[7] = '{"rand_bad",  32'd5,          1'b0, 1'b1, 1, 1'b0, 1'b1, 5};

      reset_n    = 1'b0;
      load_start = 1'b0;
      data_valid = 1'b0;
      data_in    = 32'd0;
      repeat (2) @(negedge clock);
      check("rst_ready", 32'(data_ready), 32'd0);
      check("rst_wen", 32'(mem_write_en), 32'd0);
      check("rst_pc", 32'(pc_write), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      check("rst_error", 32'(load_error), 32'd0);
      reset_n = 1'b1;
      repeat (3) begin
         data_valid = 1'b1;
         data_in    = $urandom;
         @(negedge clock);
         check("idle_hold", 32'(data_ready), 32'd0);
      end
      data_valid = 1'b0;

      for (int v = 0; v < 8; v++) begin
         run_load(vecs[v].tag, vecs[v].len, vecs[v].fixed, vecs[v].bad_csum, vecs[v].gap, 1'b1,
                  CSUM_EN ? vecs[v].ok_cs : vecs[v].ok_nocs, vecs[v].writes);
      end

      // randomized loads: outcome follows from length range and checksum agreement
      for (int r = 0; r < 6; r++) begin
         len = ($urandom_range(4, 0) == 0) ? (32'(DEPTH) + $urandom_range(3, 1)) : $urandom_range(DEPTH, 1);
         bad = ($urandom_range(2, 0) == 0);
         ok  = (len >= 1) && (len <= DEPTH) && !(CSUM_EN && bad);
         run_load("rand", len, 1'b0, bad, 1, 1'b1, ok, ((len >= 1) && (len <= DEPTH)) ? int'(len) : 0);
      end

      // reset in the cycle where the second payload write is pending
      w0 = n_writes;
      pulse_start();
      send(32'd8, 0);
      w = $urandom;
      exp_q.push_back('{addr: 6'd0, data: w});
      send(w, 0);
      data_valid = 1'b1;
      data_in    = $urandom;
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      check("arst_wen", 32'(mem_write_en), 32'd0);
      check("arst_addr", 32'(mem_write_addr), 32'd0);
      check("arst_data", mem_write_data, 32'd0);
      check("arst_ready", 32'(data_ready), 32'd0);
      check("arst_pc", 32'(pc_write), 32'd0);
      check("arst_done_err", 32'({load_done, load_error}), 32'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (5) begin
         data_valid = 1'b1;
         data_in    = $urandom;
         @(negedge clock);
         check("post_rst_idle", 32'(data_ready), 32'd0);
      end
      data_valid = 1'b0;
      check("arst_writes", 32'(n_writes - w0), 32'd1);
      check("arst_pending", 32'(exp_q.size()), 32'd0);

      // load_start during DATA is ignored, then restart from DONE
      w0 = 0;
      pulse_start();
      send(32'd4, 0);
      len = 32'd0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            load_start = 1'b1;
            data_valid = 1'b0;
            @(negedge clock);
            load_start = 1'b0;
            check("mid_start_ready", 32'(data_ready), 32'd1);
            check("mid_start_err", 32'(load_error), 32'd0);
         end
         w = $urandom;
         exp_q.push_back('{addr: 6'(i), data: w});
         len ^= w;
         send(w, 0);
      end
`ifdef LOADER_CHECKSUM_EN
      send(len, 0);
`endif
      check("mid_start_done", 32'(load_done), 32'd1);
      @(negedge clock);
      check("mid_start_pc", 32'(pc_write), 32'd1);
      pulse_start();
      check("restart_pc", 32'(pc_write), 32'd0);
      check("restart_ready", 32'(data_ready), 32'd1);
      check("restart_done", 32'(load_done), 32'd0);
      run_load("restart", 32'd2, 1'b0, 1'b0, 0, 1'b0, 1'b1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
